// File: rtl/mixcolumns_seq.sv
// mixcolumns_seq
//   Runs one shared 32-bit MixColumns column unit over a 128-bit AES state,
//   one column per cycle. It sits between SubBytes/ShiftRows and AddRoundKey
//   in an iterative round datapath. A bypass flag passes the state through
//   unchanged for the final AES round.
//
//   Parameter
//     PIPE_MC    1 = register the column result and write it back one cycle
//                later; 0 = write the result back in the same cycle.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     abort      synchronous flush to IDLE; any state in flight is dropped
//     in_valid   in_state / in_bypass valid
//     in_ready   block can accept a state (IDLE only)
//     in_bypass  1 = pass the state through unchanged
//     in_state   AES state; column c = in_state[127-32c -: 32], byte 0 = MSB
//     out_valid  out_state valid; held until out_ready
//     out_ready  downstream accepts out_state
//     out_state  transformed state, same column layout (register output)
//     busy       high in any state other than IDLE
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a state, in_ready high
//   RUN   | one column per cycle through the shared column unit
//   FLUSH | write back the last registered column (PIPE_MC=1 only)
//   DONE  | out_valid high, holding out_state until out_ready

module mix_column (
  input  logic [31:0] x,
  output logic [31:0] y
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    a0 = x[31:24];
    a1 = x[23:16];
    a2 = x[15:8];
    a3 = x[7:0];
    y[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    y[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    y[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    y[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

module mixcolumns_seq #(
  parameter bit PIPE_MC = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bypass,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t       state;
  logic [1:0]   col_cnt;
  logic [127:0] state_reg;
  logic [31:0]  pipe_y;
  logic [1:0]   pipe_col;
  logic [31:0]  col_x;
  logic [31:0]  col_y;

  // Column c lives at bit offset 32*(3-c); for a 2-bit index 3-c == ~c.
  assign col_x = state_reg[{~col_cnt, 5'b0} +: 32];

  mix_column u_mix_column (
    .x (col_x),
    .y (col_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      col_cnt   <= 2'd0;
      state_reg <= '0;
      pipe_y    <= '0;
      pipe_col  <= 2'd0;
      out_valid <= 1'b0;
    end else if (abort) begin
      // state_reg is intentionally left as is; the next accept overwrites it.
      state     <= S_IDLE;
      col_cnt   <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state_reg <= in_state;
            col_cnt   <= 2'd0;
            if (in_bypass) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          col_cnt <= col_cnt + 2'd1;
          if (!PIPE_MC) begin
            state_reg[{~col_cnt, 5'b0} +: 32] <= col_y;
            if (col_cnt == 2'd3) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end
          end else begin
            // Column 0 has nothing registered ahead of it to write back.
            pipe_y   <= col_y;
            pipe_col <= col_cnt;
            if (col_cnt != 2'd0) begin
              state_reg[{~pipe_col, 5'b0} +: 32] <= pipe_y;
            end
            if (col_cnt == 2'd3) begin
              state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          state_reg[{~pipe_col, 5'b0} +: 32] <= pipe_y;
          state     <= S_DONE;
          out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_state = state_reg;

endmodule

// File: tb/tb_mixcolumns_seq.sv
// tb_mixcolumns_seq
//   Directed bench for mixcolumns_seq. Two instances share all inputs:
//   u_dut0 with combinational write-back, u_dut1 with the registered
//   column result. Expected states are the known FIPS-197 column vectors.

module tb_mixcolumns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         abort;
  logic         in_valid;
  logic         in_bypass;
  logic [127:0] in_state;
  logic         out_ready;

  logic         in_ready_0, out_valid_0, busy_0;
  logic [127:0] out_state_0;
  logic         in_ready_1, out_valid_1, busy_1;
  logic [127:0] out_state_1;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [127:0] ST1  = 128'hdb135345_01010101_01010101_01010101;
  localparam logic [127:0] EX1  = 128'h8e4da1bc_01010101_01010101_01010101;
  localparam logic [127:0] ST2  = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] EX2  = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
  localparam logic [127:0] ST3  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] ST5  = 128'h2d26314c_2d26314c_2d26314c_2d26314c;
  localparam logic [127:0] EX5  = 128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8;

  always #5 clk = ~clk;

  mixcolumns_seq #(.PIPE_MC(1'b0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready_0),
    .in_bypass (in_bypass),
    .in_state  (in_state),
    .out_valid (out_valid_0),
    .out_ready (out_ready),
    .out_state (out_state_0),
    .busy      (busy_0)
  );

  mixcolumns_seq #(.PIPE_MC(1'b1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready_1),
    .in_bypass (in_bypass),
    .in_state  (in_state),
    .out_valid (out_valid_1),
    .out_ready (out_ready),
    .out_state (out_state_1),
    .busy      (busy_1)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One state through both instances with out_ready high; checks the
  // cycle at which out_valid first appears and the data at that point.
  task automatic run_state(input string tag, input logic [127:0] st, input logic byp,
                           input logic [127:0] exp, input int lat0_exp, input int lat1_exp);
    int lat0 = 0;
    int lat1 = 0;
    logic [127:0] d0 = '0;
    logic [127:0] d1 = '0;
    @(negedge clk);
    in_state  = st;
    in_bypass = byp;
    in_valid  = 1'b1;
    chk({tag, " in_ready"}, 128'(in_ready_0 & in_ready_1), 128'(1));
    @(negedge clk);
    in_valid  = 1'b0;
    in_bypass = ~byp;
    in_state  = '1;
    for (int n = 1; n <= 12; n++) begin
      if (out_valid_0 && lat0 == 0) begin lat0 = n; d0 = out_state_0; end
      if (out_valid_1 && lat1 == 0) begin lat1 = n; d1 = out_state_1; end
      @(negedge clk);
    end
    in_bypass = 1'b0;
    chk({tag, " lat0"}, 128'(lat0), 128'(lat0_exp));
    chk({tag, " data0"}, d0, exp);
    chk({tag, " lat1"}, 128'(lat1), 128'(lat1_exp));
    chk({tag, " data1"}, d1, exp);
  endtask

  initial begin
    logic [127:0] q_in [3];
    logic [127:0] q_ex [3];
    int  idx_in, idx_out, last_c;
    logic seen, acc;

    rst_n     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    in_state  = '0;
    out_ready = 1'b1;
    #1;
    chk("rst in_ready", 128'({in_ready_0, in_ready_1}), 128'(3));
    chk("rst out_valid", 128'({out_valid_0, out_valid_1}), 128'(0));
    chk("rst busy", 128'({busy_0, busy_1}), 128'(0));
    chk("rst out_state0", out_state_0, 128'h0);
    chk("rst out_state1", out_state_1, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_state("single col", ST1, 1'b0, EX1, 5, 6);
    run_state("full state", ST2, 1'b0, EX2, 5, 6);
    run_state("bypass", ST3, 1'b1, ST3, 1, 1);

    // Backpressure: out_ready low for 10 cycles once out_valid is up.
    out_ready = 1'b0;
    @(negedge clk);
    in_state = ST2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid_0; i++) @(negedge clk);
    chk("bp valid up", 128'(out_valid_0), 128'(1));
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid_0 || out_state_0 !== EX2 || in_ready_0) seen = 1'b1;
    end
    chk("bp held", 128'(seen), 128'(0));
    chk("bp data", out_state_0, EX2);
    chk("bp dut1 data", out_state_1, EX2);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release in_ready", 128'(in_ready_0), 128'(1));
    chk("bp release out_valid", 128'(out_valid_0), 128'(0));
    repeat (3) @(negedge clk);

    // Abort in RUN after two columns, then abort in IDLE with in_valid high.
    in_state = ST2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (out_valid_0 || out_valid_1) seen = 1'b1;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", 128'({busy_0, busy_1}), 128'(0));
    chk("abort in_ready", 128'({in_ready_0, in_ready_1}), 128'(3));
    in_state = ST5;
    in_valid = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b0;
    chk("abort idle not taken", 128'({busy_0, busy_1}), 128'(0));
    for (int i = 0; i < 8; i++) begin
      if (out_valid_0 || out_valid_1) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort no out_valid", 128'(seen), 128'(0));
    run_state("after abort", ST5, 1'b0, EX5, 5, 6);

    // Asynchronous reset between edges in the middle of RUN.
    in_state = ST2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre-rst busy", 128'(busy_0), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst in_ready", 128'({in_ready_0, in_ready_1}), 128'(3));
    chk("mid rst busy", 128'({busy_0, busy_1}), 128'(0));
    chk("mid rst out_valid", 128'({out_valid_0, out_valid_1}), 128'(0));
    chk("mid rst out_state0", out_state_0, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back with out_ready high: one result every 6 cycles (u_dut0).
    q_in[0] = ST1; q_ex[0] = EX1;
    q_in[1] = ST2; q_ex[1] = EX2;
    q_in[2] = ST5; q_ex[2] = EX5;
    idx_in  = 0;
    idx_out = 0;
    last_c  = 0;
    @(negedge clk);
    in_state = q_in[0];
    in_valid = 1'b1;
    for (int c = 0; c < 40 && idx_out < 3; c++) begin
      if (out_valid_0) begin
        chk($sformatf("b2b data %0d", idx_out), out_state_0, q_ex[idx_out]);
        if (idx_out > 0) chk($sformatf("b2b gap %0d", idx_out), 128'(c - last_c), 128'(6));
        last_c = c;
        idx_out++;
      end
      acc = in_valid && in_ready_0;
      @(negedge clk);
      if (acc) begin
        idx_in++;
        if (idx_in < 3) in_state = q_in[idx_in];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b count", 128'(idx_out), 128'(3));
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
